// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative signed multiply/divide unit beside the EX-stage
//                ALU. Owns the HI/LO registers (MFHI/MFLO read, MTHI/MTLO
//                write). MULT is shift-add and DIV is restoring division,
//                one bit per clock, followed by a single sign-fix cycle.
//                Optional build macro MDU_UNSIGNED_EN adds MULTU (24) and
//                DIVU (25).
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       alu_control,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [4:0]       c_op_mult  = 5'd10;
    localparam logic [4:0]       c_op_div   = 5'd11;
`ifdef MDU_UNSIGNED_EN
    localparam logic [4:0]       c_op_multu = 5'd24;
    localparam logic [4:0]       c_op_divu  = 5'd25;
`endif
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;
    localparam logic [1:0] c_st_fix  = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    // r_upper: running high product half / partial remainder
    // r_lower: multiplier being shifted out / dividend shifting into quotient
    logic [WIDTH-1:0] r_upper;
    logic [WIDTH-1:0] r_lower;
    logic [WIDTH-1:0] r_opnd;
    logic             r_is_div;
    logic             r_zero;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_div_by_zero;

    logic             w_is_mul;
    logic             w_is_div;
    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_trial;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    // Decode the request and derive operand signs for the accepting edge
`ifdef MDU_UNSIGNED_EN
    logic w_is_uns;
    always_comb begin
        w_is_uns = (alu_control == c_op_multu) || (alu_control == c_op_divu);
        w_is_mul = (alu_control == c_op_mult)  || (alu_control == c_op_multu);
        w_is_div = (alu_control == c_op_div)   || (alu_control == c_op_divu);
        w_a_neg  = a[WIDTH-1] & ~w_is_uns;
        w_b_neg  = b[WIDTH-1] & ~w_is_uns;
    end
`else
    always_comb begin
        w_is_mul = (alu_control == c_op_mult);
        w_is_div = (alu_control == c_op_div);
        w_a_neg  = a[WIDTH-1];
        w_b_neg  = b[WIDTH-1];
    end
`endif

    // Operand magnitudes, per-step arithmetic and final sign correction
    always_comb begin
        w_accept    = (r_state == c_st_idle) && start && (w_is_mul || w_is_div);
        w_a_mag     = w_a_neg ? (~a + 1'b1) : a;
        w_b_mag     = w_b_neg ? (~b + 1'b1) : b;
        w_mul_sum   = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_div_shift = {r_upper, r_lower[WIDTH-1]};
        w_div_trial = w_div_shift - {1'b0, r_opnd};
        w_prod_mag  = {r_upper, r_lower};
        w_prod      = r_neg_q ? (~w_prod_mag + 1'b1) : w_prod_mag;
        w_quo       = r_neg_q ? (~r_lower + 1'b1) : r_lower;
        w_rem       = r_neg_r ? (~r_upper + 1'b1) : r_upper;
    end

    // Controller and datapath: accept, iterate one bit per edge, fix signs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_cnt         <= '0;
            r_upper       <= '0;
            r_lower       <= '0;
            r_opnd        <= '0;
            r_is_div      <= 1'b0;
            r_zero        <= 1'b0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_busy        <= 1'b1;
                        r_cnt         <= '0;
                        r_div_by_zero <= 1'b0;
                        r_is_div      <= w_is_div;
                        r_neg_q       <= w_a_neg ^ w_b_neg;
                        r_neg_r       <= w_a_neg;
                        r_upper       <= '0;
                        if (w_is_mul) begin
                            r_lower <= w_b_mag;
                            r_opnd  <= w_a_mag;
                            r_zero  <= 1'b0;
                            r_state <= c_st_mul;
                        end else if (b == '0) begin
                            // Keep the raw dividend; it becomes HI in FIX
                            r_lower <= a;
                            r_opnd  <= '0;
                            r_zero  <= 1'b1;
                            r_state <= c_st_fix;
                        end else begin
                            r_lower <= w_a_mag;
                            r_opnd  <= w_b_mag;
                            r_zero  <= 1'b0;
                            r_state <= c_st_div;
                        end
                    end else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                c_st_mul: begin
                    r_upper <= w_mul_sum[WIDTH:1];
                    r_lower <= {w_mul_sum[0], r_lower[WIDTH-1:1]};
                    r_cnt   <= r_cnt + c_cnt_one;
                    if (r_cnt == c_cnt_last) r_state <= c_st_fix;
                end
                c_st_div: begin
                    // Remainder stays below the divisor, so it fits WIDTH bits
                    if (!w_div_trial[WIDTH]) begin
                        r_upper <= w_div_trial[WIDTH-1:0];
                        r_lower <= {r_lower[WIDTH-2:0], 1'b1};
                    end else begin
                        r_upper <= w_div_shift[WIDTH-1:0];
                        r_lower <= {r_lower[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + c_cnt_one;
                    if (r_cnt == c_cnt_last) r_state <= c_st_fix;
                end
                c_st_fix: begin
                    if (r_zero) begin
                        r_hi          <= r_lower;
                        r_lo          <= '1;
                        r_div_by_zero <= 1'b1;
                    end else if (r_is_div) begin
                        // Most-negative / -1 wraps naturally to 0x80..0, rem 0
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit. Vector table plus
//                random operations scored through an expected-result queue,
//                and hand-written sequences for busy/reset corner cases.
//                Honours MDU_UNSIGNED_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   alu_control;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_control (alu_control),
        .start       (start),
        .a           (a),
        .b           (b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } exp_t;

    typedef struct {
        logic [4:0]   code;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } vec_t;

    exp_t q[$];
    vec_t vecs[8];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] h, input logic [W-1:0] l,
                                input logic d, input int lat);
        exp_t e;
        e.hi = h; e.lo = l; e.dbz = d; e.lat = lat;
        return e;
    endfunction

    // Reference model built from the language's own signed arithmetic
    function automatic exp_t model(input logic [4:0] code, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t e;
        logic signed [63:0]  p;
        logic signed [W-1:0] sx;
        logic signed [W-1:0] sy;
        sx = x; sy = y;
        e = mk('0, '0, 1'b0, W + 2);
        if (code == 5'd10) begin
            p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
            e.hi = p[63:32]; e.lo = p[31:0];
        end else if (code == 5'd24) begin
            p = {32'b0, x} * {32'b0, y};
            e.hi = p[63:32]; e.lo = p[31:0];
        end else if (y == '0) begin
            e = mk(x, '1, 1'b1, 2);
        end else if (code == 5'd25) begin
            e.lo = x / y; e.hi = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000; e.hi = '0;
        end else begin
            e.lo = sx / sy; e.hi = sx % sy;
        end
        return e;
    endfunction

    // Present a request at a falling edge; return just after the sampling edge
    task automatic issue(input logic [4:0] code, input logic [W-1:0] x, input logic [W-1:0] y);
        alu_control = code; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        a = $urandom; b = $urandom;
    endtask

    // Wait (bounded) for done, then score the oldest expected result
    task automatic wait_done(input int start_cyc);
        int   cyc;
        exp_t e;
        cyc = start_cyc;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("busy_after_accept", 64'(busy), 64'd1);
        end while (!done && cyc < 200);
        if (q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_empty: got done with no expected entry, expected one entry");
        end else begin
            e = q.pop_front();
            if (!done) begin
                n_tests++; n_fail++;
                $display("FAIL done_timeout: got no done after %0d cycles, expected done at %0d", cyc, e.lat);
            end else begin
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                check("latency", 64'(cyc), 64'(e.lat));
                check("busy_at_done", 64'(busy), 64'd0);
            end
        end
    endtask

    task automatic run_op(input logic [4:0] code, input logic [W-1:0] x,
                          input logic [W-1:0] y, input exp_t e);
        q.push_back(e);
        issue(code, x, y);
        wait_done(0);
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] save_hi;
        logic [W-1:0] save_lo;
        int           n_done;

        vecs[0] = '{5'd10, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34};
        vecs[1] = '{5'd11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[2] = '{5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
        vecs[3] = '{5'd11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 2};
        vecs[4] = '{5'd11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 34};
        vecs[5] = '{5'd11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[6] = '{5'd10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34};
        vecs[7] = '{5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 34};

        reset = 1'b1; start = 1'b0; alu_control = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_dbz", 64'(div_by_zero), 64'd0);

        // Table vectors, issued back to back (start coincides with done)
        for (int i = 0; i < 8; i++)
            run_op(vecs[i].code, vecs[i].a, vecs[i].b,
                   mk(vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].lat));
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);

        // Random operations scored against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            x = $urandom;
            y = (i % 3 == 0) ? W'($urandom_range(1, 9)) : W'($urandom);
            if (i == 5) y = 32'hFFFF_FFFD;
            run_op((i % 2 == 0) ? 5'd10 : 5'd11, x, y,
                   model((i % 2 == 0) ? 5'd10 : 5'd11, x, y));
        end

        // MTHI in idle, then MTHI on the accepting edge is dropped
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h0000_CAFE;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_idle", 64'(hi), 64'h0000_CAFE);
        hi_we = 1'b1; wdata = 32'h0000_5555;
        run_op(5'd10, 32'd3, 32'd4, mk(32'h0, 32'd12, 1'b0, 34));

        // Non-MDU code is ignored
        save_hi = hi; save_lo = lo;
        issue(5'd2, 32'd9, 32'd9);
        @(negedge clk);
        check("nonmdu_busy", 64'(busy), 64'd0);
        check("nonmdu_hi", 64'(hi), 64'(save_hi));

        // Start and MTHI while busy are both ignored
        q.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34));
        issue(5'd10, 32'd7, 32'hFFFF_FFFD);
        repeat (4) @(negedge clk);
        alu_control = 5'd11; a = 32'd9; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        wait_done(6);
        @(negedge clk);
        check("no_queued_start", 64'(busy), 64'd0);

        // Reset mid-operation aborts with no done pulse
        issue(5'd10, 32'd7, 32'd3);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        lo_we = 1'b1; wdata = 32'h0000_ABCD;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_idle", 64'(lo), 64'h0000_ABCD);
        check("mtlo_hi_kept", 64'(hi), 64'd0);

`ifdef MDU_UNSIGNED_EN
        run_op(5'd24, 32'hFFFF_FFFF, 32'd2, mk(32'd1, 32'hFFFF_FFFE, 1'b0, 34));
        run_op(5'd25, 32'hFFFF_FFFF, 32'd2, mk(32'd1, 32'h7FFF_FFFF, 1'b0, 34));
        run_op(5'd25, 32'd9, 32'd0, model(5'd25, 32'd9, 32'd0));
`else
        save_hi = hi; save_lo = lo;
        issue(5'd24, 32'hFFFF_FFFF, 32'd2);
        repeat (3) @(negedge clk);
        check("multu_ignored_busy", 64'(busy), 64'd0);
        check("multu_ignored_hi", 64'(hi), 64'(save_hi));
        check("multu_ignored_lo", 64'(lo), 64'(save_lo));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
